// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx
//   Consumer of the core's output-byte strobe. Each strobed byte is pushed
//   into a small FIFO and sent out on tx as 8N1 UART. The core cannot be
//   stalled, so a byte that arrives with no FIFO space is dropped and the
//   sticky overflow flag is raised.
//
// Ports
//   clk         clock, all logic on posedge
//   reset       synchronous reset, active-high
//   stdout      byte from core, valid while stdout_en=1
//   stdout_en   write strobe, one byte per high cycle
//   tx          UART serial line, idle high
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes buffered (0..2**FIFO_AW)
//   overflow    sticky drop flag, cleared only by reset
//   tx_done     one-cycle pulse after the last stop-bit cycle
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); back-to-back frames reload from here

module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         stdout,
  input  logic               stdout_en,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               tx_done
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;

  state_e             state_q, state_d;
  logic [CW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  logic baud_end, pop, push, drop;

  assign baud_end = (baud_q == BAUD_LAST);
  // A pop happens either from IDLE or on the last stop-bit cycle, which
  // lets the next frame start with no idle gap.
  assign pop  = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  assign push = stdout_en && ((count_q != FULL) || pop);
  assign drop = stdout_en && !push;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          done_d = 1'b1;
          if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the upcoming state so it changes on the same edge
  // as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= stdout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx. A frame-level reference model (byte queue plus
// "cycles left in current frame") predicts every output on every cycle.
module tb_stdout_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    stdout = 8'h00;
  logic          stdout_en = 1'b0;
  logic          tx, busy, overflow, tx_done;
  logic [AW:0]   fifo_count;

  stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .stdout     (stdout),
    .stdout_en  (stdout_en),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] mq[$];
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  bit         ovf_m = 1'b0;
  bit         done_m = 1'b0;

  logic tx_hist[$];
  logic done_hist[$];
  int   max_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_tx();
    int k, b;
    if (rem == 0) return 1'b1;
    k = FRAME - rem;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic step(input bit en, input logic [7:0] d, input bit rst);
    bit ending, pop;
    int sz;
    stdout_en = en;
    stdout    = d;
    reset     = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      rem    = 0;
      ovf_m  = 1'b0;
      done_m = 1'b0;
    end else begin
      sz     = mq.size();
      ending = (rem == 1);
      pop    = (sz > 0) && (rem == 0 || ending);
      done_m = ending;
      if (pop) begin
        cur = mq.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (en) begin
        if (sz < 16 || pop) mq.push_back(d);
        else ovf_m = 1'b1;
      end
    end
    #1;
    tx_hist.push_back(tx);
    done_hist.push_back(tx_done);
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    check("tx", 32'(tx), 32'(model_tx()));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("busy", 32'(busy), 32'((rem > 0) || (mq.size() > 0)));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("tx_done", 32'(tx_done), 32'(done_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while ((rem != 0 || mq.size() != 0) && g < 2000) begin
      step(1'b0, 8'h00, 1'b0);
      g++;
    end
    check(tag, 32'(g < 2000), 32'd1);
    idle(3);
  endtask

  task automatic wait_rem(input int target, input string tag);
    int g;
    g = 0;
    while (rem != target && g < 200) begin
      step(1'b0, 8'h00, 1'b0);
      g++;
    end
    check(tag, 32'(g < 200), 32'd1);
  endtask

  initial begin
    int s0;
    logic [9:0] pat;

    // reset state
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // 1: single byte 'H'
    s0 = tx_hist.size();
    step(1'b1, 8'h48, 1'b0);
    idle(FRAME + 5);
    pat = {1'b1, 8'b0100_1000, 1'b0};
    for (int i = 0; i < 10; i++)
      check($sformatf("t1_bit%0d", i), 32'(tx_hist[s0 + 1 + i*CPB + CPB/2]), 32'(pat[i]));
    check("t1_done_early", 32'(done_hist[s0 + FRAME]), 32'd0);
    check("t1_done", 32'(done_hist[s0 + 1 + FRAME]), 32'd1);
    check("t1_done_late", 32'(done_hist[s0 + 2 + FRAME]), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: burst of three
    max_cnt = 0;
    step(1'b1, 8'h48, 1'b0);
    step(1'b1, 8'h69, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    wait_drain("t2_drain");
    check("t2_peak", 32'(max_cnt), 32'd2);

    // 3: overflow
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 1'b0);
    check("t3_count", 32'(fifo_count), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    wait_drain("t3_drain");
    check("t3_sticky", 32'(overflow), 32'd1);

    // 4: full FIFO with a same-edge pop
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    wait_rem(1, "t4_reach_stop");
    step(1'b1, 8'hA5, 1'b0);
    check("t4_count", 32'(fifo_count), 32'd16);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_tail", 32'(mq[mq.size()-1]), 32'hA5);
    wait_drain("t4_drain");

    // 5: reset during data bit 3 of 0xFF
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0) ? 8'hFF : 8'(i), 1'b0);
    wait_rem(FRAME - (4*CPB + 1), "t5_reach_bit3");
    check("t5_tx_pre", 32'(tx), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(tx_done), 32'd0);
    s0 = tx_hist.size();
    step(1'b1, 8'h00, 1'b0);
    wait_drain("t5_drain");
    for (int i = 0; i < FRAME; i++)
      check($sformatf("t5_line%0d", i), 32'(tx_hist[s0 + 1 + i]), 32'(i >= 9*CPB));

    // 6: 0xFF then 0x00 back-to-back
    s0 = tx_hist.size();
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    wait_drain("t6_drain");
    for (int i = 0; i < 2*FRAME; i++)
      check($sformatf("t6_line%0d", i), 32'(tx_hist[s0 + 1 + i]),
            32'((i >= CPB && i < 10*CPB) || (i >= 19*CPB && i < 20*CPB)));

    // randomized traffic with varying strobe density and rare resets
    for (int seg = 0; seg < 6; seg++) begin
      int dens;
      dens = (seg == 4) ? 60 : (seg == 5) ? 95 : 2 + 4*seg;
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 99) < dens, 8'($urandom), $urandom_range(0, 399) == 0);
    end
    wait_drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
